// File: rtl/sample_ram_ctrl.sv
// sample_ram_ctrl: ring-buffer capture sequencer with newest-first readout of the sample RAM.
// Define SAMPLE_RAM_CTRL_ABORT_EN to let abort_i cancel capture or readout.
module sample_ram_ctrl #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 3
) (
   input  logic             clk_i,
   input  logic             rst_in,
   input  logic             arm_i,
   input  logic             abort_i,
   input  logic [WIDTH-1:0] smpl_i,
   input  logic             smpl_valid_i,
   input  logic             trg_i,
   input  logic [DEPTH:0]   delay_i,
   output logic [WIDTH-1:0] rd_data_o,
   output logic             rd_valid_o,
   input  logic             rd_ready_i,
   output logic             busy_o,
   output logic             done_o,
   output logic             ram_en_o,
   output logic             ram_we_o,
   output logic [DEPTH-1:0] ram_addr_o,
   output logic [WIDTH-1:0] ram_d_o,
   input  logic [WIDTH-1:0] ram_d_i
);
   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] ARMED = 2'd1;
   localparam logic [1:0] POST  = 2'd2;
   localparam logic [1:0] READ  = 2'd3;
   localparam logic [DEPTH:0] N   = {1'b1, {DEPTH{1'b0}}};
   localparam logic [DEPTH:0] ONE = {{DEPTH{1'b0}}, 1'b1};

   logic [1:0]       state;
   logic [DEPTH-1:0] wr_ptr, rd_ptr;
   logic [DEPTH:0]   fill, post_cnt, post_cnt_max, rd_left;
   logic             done_q;
   logic             abort, we, trig, post_hit, to_read, hs;
   logic [DEPTH:0]   delay_clamp, fill_nxt;

`ifdef SAMPLE_RAM_CTRL_ABORT_EN
   assign abort = abort_i && state != IDLE;
`else
   logic unused_abort;
   assign unused_abort = abort_i;
   assign abort = 1'b0;
`endif

   assign we          = (state == ARMED || state == POST) && smpl_valid_i && !abort;
   assign trig        = state == ARMED && we && trg_i;
   assign delay_clamp = delay_i > N ? N : delay_i;
   assign fill_nxt    = fill == N ? N : fill + ONE;
   assign post_hit    = state == POST && we && post_cnt + ONE == post_cnt_max;
   assign to_read     = (trig && delay_clamp == '0) || post_hit;
   assign hs          = state == READ && rd_ready_i && !abort;

   assign rd_valid_o = state == READ;
   assign rd_data_o  = rd_valid_o ? ram_d_i : '0;
   assign ram_we_o   = we;
   assign ram_en_o   = we | rd_valid_o;
   assign ram_addr_o = rd_valid_o ? rd_ptr : wr_ptr;
   assign ram_d_o    = smpl_i;
   assign busy_o     = state != IDLE;
   assign done_o     = done_q;

   // The write address of the final capture sample is the newest entry, so readout starts there.
   always_ff @(posedge clk_i) begin
      if (!rst_in) begin
         state        <= IDLE;
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         fill         <= '0;
         post_cnt     <= '0;
         post_cnt_max <= '0;
         rd_left      <= '0;
         done_q       <= 1'b0;
      end else begin
         done_q <= hs && rd_left == ONE;
         if (abort) begin
            state <= IDLE;
         end else if (state == IDLE && arm_i) begin
            state  <= ARMED;
            wr_ptr <= '0;
            fill   <= '0;
         end else if (we) begin
            wr_ptr <= wr_ptr + ONE[DEPTH-1:0];
            fill   <= fill_nxt;
            if (trig) begin
               post_cnt_max <= delay_clamp;
               post_cnt     <= '0;
               state        <= POST;
            end
            if (state == POST) post_cnt <= post_cnt + ONE;
            if (to_read) begin
               state   <= READ;
               rd_ptr  <= wr_ptr;
               rd_left <= fill_nxt;
            end
         end else if (hs) begin
            rd_ptr  <= rd_ptr - ONE[DEPTH-1:0];
            rd_left <= rd_left - ONE;
            if (rd_left == ONE) state <= IDLE;
         end
      end
   end
endmodule

// File: tb/tb_sample_ram_ctrl.sv
// tb_sample_ram_ctrl: directed and randomized captures checked against a sample-history model.
module tb_sample_ram_ctrl;
   localparam int W = 32;
   localparam int D = 3;
   localparam int N = 8;

   logic clk = 0, rst_n = 0, arm = 0, abort = 0, sv = 0, trg = 0, rdy = 0;
   logic [W-1:0] smpl = '0;
   logic [D:0]   dly = '0;
   logic [W-1:0] rd_data_o, ram_d_o, ram_d_i;
   logic         rd_valid_o, busy_o, done_o, ram_en_o, ram_we_o;
   logic [D-1:0] ram_addr_o;
   logic [W-1:0] mem [N];
   logic [W-1:0] hist [$];
   int checks = 0, errors = 0;

   sample_ram_ctrl #(.WIDTH(W), .DEPTH(D)) dut (
      .clk_i(clk), .rst_in(rst_n), .arm_i(arm), .abort_i(abort),
      .smpl_i(smpl), .smpl_valid_i(sv), .trg_i(trg), .delay_i(dly),
      .rd_data_o(rd_data_o), .rd_valid_o(rd_valid_o), .rd_ready_i(rdy),
      .busy_o(busy_o), .done_o(done_o), .ram_en_o(ram_en_o), .ram_we_o(ram_we_o),
      .ram_addr_o(ram_addr_o), .ram_d_o(ram_d_o), .ram_d_i(ram_d_i)
   );

   always #5 clk = ~clk;
   always @(posedge clk) if (ram_en_o && ram_we_o) mem[ram_addr_o] <= ram_d_o;
   assign ram_d_i = mem[ram_addr_o];

   task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [W-1:0] val(input bit rnd, input logic [W-1:0] base, input int n);
      return rnd ? W'($urandom) : base + W'(n);
   endfunction

   task automatic arm_dut;
      arm = 1;
      tick;
      arm = 0;
      hist.delete();
      chk("busy_after_arm", busy_o, 1);
   endtask

   task automatic put(input logic [W-1:0] d, input logic t, input logic [D:0] dl);
      smpl = d; sv = 1; trg = t; dly = dl;
      #1;
      chk("we", ram_we_o, 1);
      chk("waddr", ram_addr_o, hist.size() % N);
      tick;
      hist.push_back(d);
      sv = 0; trg = 0;
   endtask

   // Invalid-strobe cycle with spurious trigger and arm, both of which must be ignored.
   task automatic gap;
      if ($urandom_range(0, 2) == 0) begin
         trg = 1; arm = 1; smpl = $urandom;
         #1;
         chk("we_idle", ram_we_o, 0);
         tick;
         trg = 0; arm = 0;
      end
   endtask

   task automatic readout(input bit bp);
      int k = hist.size() < N ? hist.size() : N;
      int idx = 0;
      int budget = 0;
      while (idx < k && budget < 200) begin
         rdy = bp ? ($urandom_range(0, 1) == 1) : 1'b1;
         #1;
         chk("rvalid", rd_valid_o, 1);
         if (rd_valid_o !== 1'b1) break;
         chk("rdata", rd_data_o, hist[hist.size() - 1 - idx]);
         chk("done_early", done_o, 0);
         chk("ram_we_read", ram_we_o, 0);
         tick;
         if (rdy) idx++;
         budget++;
      end
      rdy = 0;
      chk("words", idx, k);
      chk("done", done_o, 1);
      chk("busy_fall", busy_o, 0);
      chk("rvalid_end", rd_valid_o, 0);
      tick;
      chk("done_pulse", done_o, 0);
   endtask

   task automatic capture(input int npre, input int dl, input bit rnd, input logic [W-1:0] base, input bit bp);
      int post = dl > N ? N : dl;
      int c = 0;
      arm_dut;
      for (int i = 0; i < npre; i++) begin
         put(val(rnd, base, c++), 0, (D+1)'($urandom_range(0, 15)));
         if (rnd) gap;
      end
      put(val(rnd, base, c++), 1, (D+1)'(dl));
      for (int i = 0; i < post; i++) begin
         chk("no_early_read", rd_valid_o, 0);
         if (rnd) gap;
         put(val(rnd, base, c++), 0, (D+1)'($urandom_range(0, 15)));
      end
      readout(bp);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_busy"}, busy_o, 0);
      chk({tag, "_done"}, done_o, 0);
      chk({tag, "_rvalid"}, rd_valid_o, 0);
      chk({tag, "_en"}, ram_en_o, 0);
      chk({tag, "_we"}, ram_we_o, 0);
      chk({tag, "_addr"}, ram_addr_o, 0);
      chk({tag, "_rdata"}, rd_data_o, 0);
   endtask

   initial begin
      tick;
      tick;
      chk_zero("reset");
      rst_n = 1;
      tick;
      capture(11, 0, 0, 'h10, 0);
      capture(0, 3, 0, 'h20, 0);
      capture(2, 0, 0, 'hA, 0);
      capture(5, 4, 1, '0, 1);
      capture(3, 12, 1, '0, 1);
      for (int r = 0; r < 6; r++)
         capture($urandom_range(0, 14), $urandom_range(0, 10), 1, '0, $urandom_range(0, 1) == 1);
      arm_dut;
      for (int i = 0; i < 4; i++) put($urandom, 0, 0);
      put($urandom, 1, 0);
      rdy = 1;
      tick;
      tick;
      rdy = 0;
      rst_n = 0;
      tick;
      chk_zero("mid_read_reset");
      rst_n = 1;
      tick;
      capture(6, 2, 1, '0, 1);
      arm_dut;
      put('h55, 1, 3);
      put('h56, 0, 0);
`ifdef SAMPLE_RAM_CTRL_ABORT_EN
      abort = 1; sv = 1; smpl = 'h57;
      tick;
      abort = 0;
      #1;
      chk("abort_busy", busy_o, 0);
      chk("abort_we", ram_we_o, 0);
      chk("abort_rvalid", rd_valid_o, 0);
      chk("abort_done", done_o, 0);
      tick;
      chk("abort_done2", done_o, 0);
      sv = 0;
`else
      abort = 1;
      put('h57, 0, 0);
      abort = 0;
      chk("abort_ignored_busy", busy_o, 1);
      put('h58, 0, 0);
      readout(0);
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/sample_ram_ctrl.md
# sample_ram_ctrl

Capture sequencer for the analyzer's distributed sample RAM (`lutram`). It writes incoming samples into the RAM as a ring buffer while armed. On a trigger it stores a programmable number of post-trigger samples, then streams the captured words newest-first over a valid/ready port to the transmit path. It sits between the sampler/trigger stage and the UART readout logic and is the only master of the RAM ports.

## Interface
Parameters:
- `WIDTH`, 32, sample and RAM word width
- `DEPTH`, 3, RAM address width; capacity `N = 2**DEPTH` words

Ports:
- `clk_i` in 1: system clock
- `rst_in` in 1: reset; synchronous, active-low
- `arm_i` in 1: start capture (honoured in IDLE only)
- `abort_i` in 1: cancel capture/readout (see Configuration)
- `smpl_i` in WIDTH: sample data
- `smpl_valid_i` in 1: sample strobe
- `trg_i` in 1: trigger hit, qualified by `smpl_valid_i`
- `delay_i` in DEPTH+1: post-trigger sample count, 0..N; sampled on trigger
- `rd_data_o` out WIDTH: readout word
- `rd_valid_o` out 1: readout word valid
- `rd_ready_i` in 1: readout consumer ready
- `busy_o` out 1: state ≠ IDLE
- `done_o` out 1: one-cycle pulse after the last readout word
- `ram_en_o`, `ram_we_o` out 1: RAM enable / write enable
- `ram_addr_o` out DEPTH: RAM address
- `ram_d_o` out WIDTH: RAM write data
- `ram_d_i` in WIDTH: RAM read data (asynchronous read)

## Operation
- State machine transitions:
  - IDLE → ARMED on `arm_i`.
  - ARMED → POST on `smpl_valid_i && trg_i`.
  - POST → READ when the post-trigger counter reaches `delay_i`.
  - READ → IDLE after the last handshake.
- Entering ARMED clears `wr_ptr` and `fill`.
- Write rules in ARMED and POST:
  - Each `smpl_valid_i` cycle writes `smpl_i` at `wr_ptr`.
  - `wr_ptr` increments modulo N (wrap-around is silent).
  - `fill` (DEPTH+1 bits) increments, saturating at N.
- Trigger handling:
  - The trigger sample itself is written in ARMED.
  - The trigger latches `delay_i` into `post_cnt_max` and clears `post_cnt`.
  - In POST, each valid sample increments `post_cnt`. The write that makes `post_cnt == post_cnt_max` is the last one.
  - With `delay_i == 0`, the FSM goes ARMED → READ directly on the trigger edge.
  - `delay_i > N` is clamped to N.
- Readout in READ:
  - `rd_ptr` starts at `wr_ptr - 1` (newest sample) and `rd_left` starts at `fill`.
  - `ram_addr_o = rd_ptr`, `rd_data_o = ram_d_i`, `rd_valid_o = 1`.
  - On `rd_valid_o && rd_ready_i`: `rd_ptr` decrements modulo N and `rd_left` decrements.
  - When `rd_left == 1` and the handshake occurs: go to IDLE and assert `done_o` in the next cycle.
- RAM control:
  - `ram_we_o = smpl_valid_i` in ARMED/POST, else 0.
  - `ram_en_o = ram_we_o | (state == READ)`.
  - `ram_d_o = smpl_i`.
  - `ram_addr_o = wr_ptr` outside READ.
- `arm_i` is ignored outside IDLE.
- `trg_i` is ignored outside ARMED, and ignored without `smpl_valid_i`.

## Timing
- Reset (`rst_in == 0` at a clock edge), including mid-capture or mid-readout:
  - State → IDLE.
  - `wr_ptr`, `rd_ptr`, `fill`, `post_cnt` → 0.
  - All outputs 0 from the next cycle: `busy_o`, `done_o`, `rd_valid_o`, `ram_en_o`, `ram_we_o`, `ram_addr_o`, `rd_data_o`.
  - RAM contents are not cleared.
- RAM writes occur at the same edge as the accepted sample (zero latency).
- `busy_o` rises the cycle after `arm_i`.
- Readout timing:
  - First `rd_valid_o` occurs the cycle after the last post-trigger write.
  - One word per cycle with `rd_ready_i` held high.
  - `rd_data_o` is held stable while `rd_valid_o && !rd_ready_i`.
- `done_o` is high exactly one cycle, coincident with `busy_o` falling.
- Trigger on the last ARMED sample with `delay_i == 0`: write and transition happen at the same edge.
- Capture after fewer than N samples: exactly `fill` words are read out; the FSM never reads unwritten entries.

## Configuration
- `SAMPLE_RAM_CTRL_ABORT_EN`:
  - Defined: `abort_i` high in ARMED, POST or READ returns the FSM to IDLE at the next edge. `busy_o` drops, `done_o` is not pulsed, `rd_valid_o` drops, and no further RAM writes occur.
  - Undefined: `abort_i` is ignored and only `rst_in` cancels an operation.

## Test plan
- Ring wrap:
  - Stimulus (DEPTH=3): arm; feed 0x10..0x1B (12 samples); trigger on 0x1B with `delay_i=0`; `rd_ready_i=1`.
  - Required response: 8 words 0x1B,0x1A,…,0x14 on consecutive cycles, then `done_o` pulse.
- Post-trigger delay:
  - Stimulus: trigger on 0x20 with `delay_i=3`, then samples 0x21..0x23.
  - Required response: readout starts with 0x23,0x22,0x21,0x20.
- Partial fill:
  - Stimulus: arm; feed 3 samples 0xA,0xB,0xC; trigger on 0xC with `delay_i=0`.
  - Required response: exactly 3 words 0xC,0xB,0xA, then `done_o`.
- Backpressure:
  - Stimulus: toggle `rd_ready_i` 1/0 during readout.
  - Required response: `rd_data_o` holds while not ready; no word is skipped or duplicated.
- Mid-readout reset:
  - Stimulus: `rst_in=0` during READ.
  - Required response: all outputs 0 next cycle; a following arm/trigger capture reads correctly.
- Abort (macro defined):
  - Stimulus: `abort_i` in POST.
  - Required response: IDLE next cycle, no `done_o`, `ram_we_o` stays 0 despite `smpl_valid_i`.
